// File: rtl/alu_pkg.sv
// alu_pkg: op codes, ALU selects, status bit positions
// and the sequencer state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SINGLE = 2'd0,
    OP_ADD128 = 2'd1,
    OP_SUB128 = 2'd2,
    OP_MUL64  = 2'd3
  } op_e;

  localparam logic [4:0] SEL_ADD = 5'b10000;
  localparam logic [4:0] SEL_SUB = 5'b10001;
  localparam logic [4:0] SEL_AND = 5'b10100;
  localparam logic [4:0] SEL_OR  = 5'b00100;
  localparam logic [4:0] SEL_XOR = 5'b01100;
  localparam logic [4:0] SEL_NOT = 5'b01110;

  localparam int ST_V = 3;
  localparam int ST_C = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC_LO,
    S_EXEC_HI,
    S_MUL,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// alu_seq_mul_iter: multiplicand/multiplier shifters and
// iteration counter for the shift-add multiply.
module alu_seq_mul_iter #(
  parameter int W         = 64,
  parameter int MUL_ITERS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_step,
  input  logic [W-1:0] i_mcand,
  input  logic [W-1:0] i_mplier,
  output logic [W-1:0] o_mcand,
  output logic         o_bit,
  output logic         o_last
);

  localparam logic [6:0] LAST = 7'(MUL_ITERS - 1);

  logic [W-1:0] r_mcand;
  logic [W-1:0] r_mplier;
  logic [6:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 7'd1;
    end
  end

  assign o_mcand = r_mcand;
  assign o_bit   = r_mplier[0];
  assign o_last  = (r_cnt == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives the shared ALU one pass per cycle to
// run single ops, 128-bit add/sub and 64x64 shift-add multiply.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W         = 64,
  parameter int MUL_ITERS = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [4:0]     cmd_sel,
  input  logic           cmd_cin,
  input  logic [2*W-1:0] cmd_a,
  input  logic [2*W-1:0] cmd_b,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [4:0]     alu_sel,
  output logic [1:0]     alu_cin,
  input  logic [W-1:0]   alu_out,
  input  logic [1:0]     alu_cout,
  input  logic [3:0]     alu_status,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic [3:0]     rsp_status
);

  state_e         r_state;
  state_e         w_next;
  op_e            r_op;
  logic [4:0]     r_sel;
  logic           r_cin;
  logic [2*W-1:0] r_a;
  logic [2*W-1:0] r_b;
  logic [W-1:0]   r_acc;
  logic           r_carry;
  logic           r_zlo;
  logic [2*W-1:0] r_data;
  logic [3:0]     r_status;

  logic         w_start;
  logic         w_step;
  logic [W-1:0] w_mcand;
  logic         w_bit;
  logic         w_last;
  logic [W-1:0] w_acc_nxt;
  logic         w_unused;

  alu_seq_mul_iter #(
    .W         (W),
    .MUL_ITERS (MUL_ITERS)
  ) u_mul_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_step   (w_step),
    .i_mcand  (r_a[W-1:0]),
    .i_mplier (r_b[W-1:0]),
    .o_mcand  (w_mcand),
    .o_bit    (w_bit),
    .o_last   (w_last)
  );

  assign w_unused  = alu_cout[1];
  assign w_acc_nxt = w_bit ? alu_out : r_acc;
  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data   = r_data;
  assign rsp_status = r_status;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_step  = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = SEL_ADD;
    alu_cin = 2'b00;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_next = S_EXEC_LO;
      end
      S_EXEC_LO: begin
        alu_a = r_a[W-1:0];
        alu_b = r_b[W-1:0];
        unique case (r_op)
          OP_SINGLE: begin
            alu_sel = r_sel;
            alu_cin = {1'b0, r_cin};
            w_next  = S_DONE;
          end
          OP_ADD128: begin
            w_next = S_EXEC_HI;
          end
          OP_SUB128: begin
            alu_sel = SEL_SUB;
            alu_cin = 2'b01;
            w_next  = S_EXEC_HI;
          end
          OP_MUL64: begin
            w_start = 1'b1;
            w_next  = S_MUL;
          end
        endcase
      end
      S_EXEC_HI: begin
        alu_a   = r_a[2*W-1:W];
        alu_b   = r_b[2*W-1:W];
        alu_sel = (r_op == OP_SUB128) ? SEL_SUB : SEL_ADD;
        alu_cin = {1'b0, r_carry};
        w_next  = S_DONE;
      end
      S_MUL: begin
        alu_a  = r_acc;
        alu_b  = w_mcand;
        w_step = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_SINGLE;
      r_sel    <= '0;
      r_cin    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_zlo    <= 1'b0;
      r_data   <= '0;
      r_status <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op  <= op_e'(cmd_op);
            r_sel <= cmd_sel;
            r_cin <= cmd_cin;
            r_a   <= cmd_a;
            r_b   <= cmd_b;
          end
        end
        S_EXEC_LO: begin
          if (r_op == OP_SINGLE) begin
            r_data   <= {{W{1'b0}}, alu_out};
            r_status <= alu_status;
          end else if (r_op == OP_MUL64) begin
            r_acc <= '0;
          end else begin
            r_data[W-1:0] <= alu_out;
            r_carry       <= alu_cout[0];
            r_zlo         <= alu_status[ST_Z];
          end
        end
        S_EXEC_HI: begin
          r_data[2*W-1:W] <= alu_out;
          r_status <= {alu_status[ST_V], alu_status[ST_C],
                       alu_status[ST_N],
                       r_zlo & alu_status[ST_Z]};
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_data   <= {{W{1'b0}}, w_acc_nxt};
            r_status <= {2'b00, w_acc_nxt[W-1], ~|w_acc_nxt};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random and directed commands against a
// behavioural ALU, scored by a queue-based response monitor.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W         = 64;
  localparam int MUL_ITERS = 64;

  typedef struct {
    logic [2*W-1:0] data;
    logic [3:0]     st;
    int             lat;
    int             acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [4:0]     cmd_sel;
  logic           cmd_cin;
  logic [2*W-1:0] cmd_a;
  logic [2*W-1:0] cmd_b;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [4:0]     alu_sel;
  logic [1:0]     alu_cin;
  logic [W-1:0]   alu_out;
  logic [1:0]     alu_cout;
  logic [3:0]     alu_status;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_data;
  logic [3:0]     rsp_status;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q[$];
  logic bp_mode  = 1'b1;
  logic bp_val   = 1'b0;
  logic [4:0] sels [6] = '{SEL_ADD, SEL_SUB, SEL_AND,
                           SEL_OR, SEL_XOR, SEL_NOT};

  alu_sequencer #(.W(W), .MUL_ITERS(MUL_ITERS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_sel    (cmd_sel),
    .cmd_cin    (cmd_cin),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_status (alu_status),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: {status[3:0], cout, out}
  function automatic logic [W+4:0] alu_f(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [4:0] sel, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] y;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    y = '0;
    s = '0;
    case (sel)
      SEL_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        y = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      SEL_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
        y = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      SEL_AND: y = a & b;
      SEL_OR:  y = a | b;
      SEL_XOR: y = a ^ b;
      SEL_NOT: y = ~a;
      default: y = '0;
    endcase
    return {v, c, y[W-1], (y == '0), c, y};
  endfunction

  logic [W+4:0] w_alu;
  always_comb w_alu = alu_f(alu_a, alu_b, alu_sel, alu_cin[0]);
  assign alu_out    = w_alu[W-1:0];
  assign alu_cout   = {1'b0, w_alu[W]};
  assign alu_status = w_alu[W+4:W+1];

  always @(posedge clk) begin
    #2;
    rsp_ready = bp_mode ? bp_val : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [2*W-1:0] act,
                     input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference results from whole-width arithmetic
  function automatic exp_t model(input logic [1:0] op,
    input logic [4:0] sel, input logic cin,
    input logic [2*W-1:0] a, input logic [2*W-1:0] b);
    exp_t           e;
    logic [W+4:0]   r;
    logic [2*W:0]   s;
    logic [2*W-1:0] d;
    logic [W-1:0]   p;
    e.acc = 0;
    case (op)
      2'd0: begin
        r = alu_f(a[W-1:0], b[W-1:0], sel, cin);
        e.data = {{W{1'b0}}, r[W-1:0]};
        e.st   = r[W+4:W+1];
        e.lat  = 1;
      end
      2'd1: begin
        s = {1'b0, a} + {1'b0, b};
        d = s[2*W-1:0];
        e.data = d;
        e.st = {(a[2*W-1] == b[2*W-1]) && (d[2*W-1] != a[2*W-1]),
                s[2*W], d[2*W-1], d == '0};
        e.lat = 2;
      end
      2'd2: begin
        d = a - b;
        e.data = d;
        e.st = {(a[2*W-1] != b[2*W-1]) && (d[2*W-1] != a[2*W-1]),
                a >= b, d[2*W-1], d == '0};
        e.lat = 2;
      end
      default: begin
        p = a[W-1:0] * b[W-1:0];
        e.data = {{W{1'b0}}, p};
        e.st   = {2'b00, p[W-1], p == '0};
        e.lat  = 1 + MUL_ITERS;
      end
    endcase
    return e;
  endfunction

  task automatic push_exp();
    exp_t e;
    e = model(cmd_op, cmd_sel, cmd_cin, cmd_a, cmd_b);
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] sel,
    input logic cin, input logic [2*W-1:0] a,
    input logic [2*W-1:0] b);
    int n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_sel = sel;
    cmd_cin = cin;
    cmd_a = a;
    cmd_b = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 400);
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    else push_exp();
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  logic           prev_valid = 1'b0;
  logic           prev_rdy   = 1'b0;
  logic [2*W-1:0] prev_data;
  logic [3:0]     prev_st;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_rdy   = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (q.size() == 0) chk("spurious_rsp", rsp_valid, 0);
        else chk("latency", cyc - q[0].acc - 1, q[0].lat);
      end
      if (rsp_valid && prev_valid && !prev_rdy) begin
        chk("hold_data", rsp_data, prev_data);
        chk("hold_status", rsp_status, prev_st);
      end
      if (rsp_valid && rsp_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_status", rsp_status, e.st);
      end
      prev_valid = rsp_valid;
      prev_rdy   = rsp_ready;
      prev_data  = rsp_data;
      prev_st    = rsp_status;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] op;
    logic [4:0] sel;
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_sel = 5'd0;
    cmd_cin = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, SEL_ADD);
    chk("rst_alu_cin", alu_cin, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bp_val = 1'b1;

    send(2'd0, SEL_SUB, 1'b1, 128'd3, 128'd2);
    send(2'd1, 5'd0, 1'b0, {64'd0, {64{1'b1}}}, {64'd0, 64'd1});
    send(2'd2, 5'd9, 1'b1, 128'd0, {64'd0, 64'd1});
    send(2'd3, 5'd0, 1'b0, 128'd7, 128'd6);
    send(2'd3, 5'd0, 1'b0, 128'd0, 128'd5);
    send(2'd0, 5'b11111, 1'b0, 128'd5, 128'd6);
    drain();

    // backpressure with a waiting command
    bp_val = 1'b0;
    send(2'd0, SEL_XOR, 1'b0, 128'hF0F0, 128'h0FF1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    cmd_sel = 5'd0;
    cmd_cin = 1'b0;
    cmd_a = {64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    cmd_b = {64'd2, 64'd3};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
    end
    @(posedge clk);
    #1 bp_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", cmd_ready, 1);
    chk("bp_idle_valid", rsp_valid, 0);
    push_exp();
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain();

    // reset during multiply iteration 30
    send(2'd3, 5'd0, 1'b0, 128'hDEAD_BEEF, 128'h1234_5678);
    repeat (31) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_alu_a", alu_a, 0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("abort_no_rsp", n, 0);

    // randomized traffic with random backpressure
    bp_mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      sel = sels[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) sel = 5'($urandom_range(0, 31));
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a[W-1:0] = '1;
      if ($urandom_range(0, 5) == 0) b = '0;
      if ($urandom_range(0, 5) == 0) a = b;
      send(op, sel, 1'($urandom_range(0, 1)), a, b);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
